// File: rtl/rv32i_wb_pkg.sv
// Shared types and constants for the Wishbone-to-async-SRAM responder.
package rv32i_wb_pkg;

  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  localparam logic SRAM_HALF_LO = 1'b0;
  localparam logic SRAM_HALF_HI = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_ACK  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

endpackage

// File: rtl/rv32i_sram_phase_timer.sv
// Halfword phase timer: a down-counter that marks the write-strobe window
// (every cycle of a phase except setup) and the last cycle of the phase.
module rv32i_sram_phase_timer #(
  parameter int WAIT_STATES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic strobe_en,
  output logic strobe_window,
  output logic phase_last
);
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_STATES + 1);

  logic [CNT_W-1:0] count_r;

  // strobe_window is registered so the SRAM write strobe leaves a flop directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r       <= '0;
      strobe_window <= 1'b0;
    end else if (load) begin
      count_r       <= LOAD_VAL;
      strobe_window <= 1'b0;
    end else if (count_r != '0) begin
      count_r       <= count_r - CNT_W'(1);
      strobe_window <= strobe_en;
    end else begin
      strobe_window <= 1'b0;
    end
  end

  assign phase_last = (count_r == '0);

endmodule

// File: rtl/rv32i_wb_sram_slave.sv
// Wishbone classic word responder backed by an asynchronous 16-bit SRAM.
// Each word access becomes up to two halfword phases; out-of-range words end in err_o.
module rv32i_wb_sram_slave
  import rv32i_wb_pkg::*;
#(
  parameter int ADDR_W      = 30,
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_STATES = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic [ADDR_W-1:0]      adr_i,
  input  logic [WB_DAT_W-1:0]    dat_i,
  output logic [WB_DAT_W-1:0]    dat_o,
  input  logic                   we_i,
  input  logic [WB_SEL_W-1:0]    sel_i,
  input  logic                   cyc_i,
  input  logic                   stb_i,
  output logic                   ack_o,
  output logic                   err_o,
  output logic [SRAM_ADDR_W-1:0] sram_addr_o,
  input  logic [15:0]            sram_dat_i,
  output logic [15:0]            sram_dat_o,
  output logic                   sram_dat_oe_o,
  output logic                   sram_ce_no,
  output logic                   sram_oe_no,
  output logic                   sram_we_no,
  output logic                   sram_lb_no,
  output logic                   sram_ub_no
);
  localparam int WORD_W = SRAM_ADDR_W - 1;

  state_t              state_r, state_s;
  logic [WORD_W-1:0]   adr_r, adr_s;
  logic [WB_DAT_W-1:0] dat_r, dat_s;
  logic                we_r, we_s;
  logic [WB_SEL_W-1:0] sel_r, sel_s;
  logic                in_phase_s, phase_next_s, half_next_s, load_s;
  logic                strobe_window_s, phase_last_s;
  logic [1:0]          half_sel_s;
  logic [15:0]         half_dat_s;

  rv32i_sram_phase_timer #(.WAIT_STATES(WAIT_STATES)) u_timer (
    .clk          (clk_i),
    .rst_n        (reset_ni),
    .load         (load_s),
    .strobe_en    (we_r),
    .strobe_window(strobe_window_s),
    .phase_last   (phase_last_s)
  );

  assign sram_we_no = ~strobe_window_s;

  // Next state plus the request fields as they will be after this edge
  always_comb begin
    state_s = state_r;
    adr_s   = adr_r;
    dat_s   = dat_r;
    we_s    = we_r;
    sel_s   = sel_r;
    case (state_r)
      ST_IDLE: begin
        if (cyc_i && stb_i) begin
          if (|adr_i[ADDR_W-1:WORD_W]) begin
            state_s = ST_ERR;
          end else begin
            adr_s = adr_i[WORD_W-1:0];
            dat_s = dat_i;
            we_s  = we_i;
            sel_s = sel_i;
            if (|sel_i[1:0])      state_s = ST_LO;
            else if (|sel_i[3:2]) state_s = ST_HI;
            else                  state_s = ST_ACK;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LO: begin
        if (!phase_last_s)    state_s = ST_LO;
        else if (!cyc_i)      state_s = ST_IDLE;
        else if (|sel_r[3:2]) state_s = ST_HI;
        else                  state_s = ST_ACK;
      end
      ST_HI: begin
        if (!phase_last_s) state_s = ST_HI;
        else if (!cyc_i)   state_s = ST_IDLE;
        else               state_s = ST_ACK;
      end
      ST_ACK:  state_s = ST_IDLE;
      ST_ERR:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
    in_phase_s   = (state_r == ST_LO) || (state_r == ST_HI);
    phase_next_s = (state_s == ST_LO) || (state_s == ST_HI);
    half_next_s  = (state_s == ST_HI) ? SRAM_HALF_HI : SRAM_HALF_LO;
    load_s       = phase_next_s && (state_s != state_r);
    half_sel_s   = (half_next_s == SRAM_HALF_HI) ? sel_s[3:2] : sel_s[1:0];
    half_dat_s   = (half_next_s == SRAM_HALF_HI) ? dat_s[31:16] : dat_s[15:0];
  end

  // SRAM pins are computed from the next state so they change right on the phase edge
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r       <= ST_IDLE;
      adr_r         <= '0;
      dat_r         <= '0;
      we_r          <= 1'b0;
      sel_r         <= '0;
      ack_o         <= 1'b0;
      err_o         <= 1'b0;
      dat_o         <= '0;
      sram_addr_o   <= '0;
      sram_dat_o    <= 16'h0000;
      sram_dat_oe_o <= 1'b0;
      sram_ce_no    <= 1'b1;
      sram_oe_no    <= 1'b1;
      sram_lb_no    <= 1'b1;
      sram_ub_no    <= 1'b1;
    end else begin
      state_r       <= state_s;
      adr_r         <= adr_s;
      dat_r         <= dat_s;
      we_r          <= we_s;
      sel_r         <= sel_s;
      ack_o         <= (state_s == ST_ACK);
      err_o         <= (state_s == ST_ERR);
      sram_ce_no    <= ~phase_next_s;
      sram_oe_no    <= ~(phase_next_s & ~we_s);
      sram_dat_oe_o <= phase_next_s & we_s;
      if (phase_next_s) begin
        sram_addr_o <= {adr_s, half_next_s};
        sram_lb_no  <= ~half_sel_s[0];
        sram_ub_no  <= ~half_sel_s[1];
        if (we_s) sram_dat_o <= half_dat_s;
      end else begin
        sram_lb_no <= 1'b1;
        sram_ub_no <= 1'b1;
      end
      // Unfetched read halves deliberately keep their previous contents
      if (in_phase_s && phase_last_s && !we_r) begin
        if (state_r == ST_HI) dat_o[31:16] <= sram_dat_i;
        else                  dat_o[15:0]  <= sram_dat_i;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_wb_sram_slave.sv
// Directed bench for rv32i_wb_sram_slave with a halfword SRAM model and a
// word-level reference memory feeding a response scoreboard.
module tb_rv32i_wb_sram_slave;
  import rv32i_wb_pkg::*;

  localparam int WAIT = 1;
  localparam int P    = WAIT + 2;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic [29:0] adr_i;
  logic [31:0] dat_i, dat_o;
  logic        we_i, cyc_i, stb_i, ack_o, err_o;
  logic [3:0]  sel_i;
  logic [17:0] sram_addr_o;
  logic [15:0] sram_dat_i, sram_dat_o;
  logic        sram_dat_oe_o, sram_ce_no, sram_oe_no, sram_we_no, sram_lb_no, sram_ub_no;

  rv32i_wb_sram_slave #(.ADDR_W(30), .SRAM_ADDR_W(18), .WAIT_STATES(WAIT)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .sel_i(sel_i), .cyc_i(cyc_i), .stb_i(stb_i), .ack_o(ack_o), .err_o(err_o),
    .sram_addr_o(sram_addr_o), .sram_dat_i(sram_dat_i), .sram_dat_o(sram_dat_o),
    .sram_dat_oe_o(sram_dat_oe_o), .sram_ce_no(sram_ce_no), .sram_oe_no(sram_oe_no),
    .sram_we_no(sram_we_no), .sram_lb_no(sram_lb_no), .sram_ub_no(sram_ub_no)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM model (small window of the address space)
  logic [15:0] sram_mem [0:1023];
  assign sram_dat_i = (!sram_ce_no && !sram_oe_no) ? sram_mem[sram_addr_o[9:0]] : 16'h0000;
  always @(posedge clk) begin
    if (!sram_ce_no && !sram_we_no && sram_dat_oe_o) begin
      if (!sram_lb_no) sram_mem[sram_addr_o[9:0]][7:0]  <= sram_dat_o[7:0];
      if (!sram_ub_no) sram_mem[sram_addr_o[9:0]][15:8] <= sram_dat_o[15:8];
    end
  end

  int errors = 0;
  int checks = 0;

  typedef struct { string tag; bit is_err; logic [31:0] dat; bit chk_dat; int lat; } exp_t;
  exp_t sb[$];
  logic [31:0] ref_mem [int];
  logic [39:0] trace [0:63];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 32'h0000_0000;
  endfunction

  task automatic ref_write(input int a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = ref_read(a);
    for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
    ref_mem[a] = w;
  endtask

  task automatic expect_resp(input string tag, input bit is_err, input logic [31:0] d,
                             input bit chk, input int lat);
    exp_t e;
    e.tag = tag; e.is_err = is_err; e.dat = d; e.chk_dat = chk; e.lat = lat;
    sb.push_back(e);
  endtask

  // Call right after a negedge while the DUT is idle; the next posedge is the sampling edge.
  task automatic issue(input logic [29:0] a, input logic [31:0] d, input logic w, input logic [3:0] s);
    adr_i = a; dat_i = d; we_i = w; sel_i = s; cyc_i = 1'b1; stb_i = 1'b1;
  endtask

  task automatic collect(input bit release_bus, input logic [29:0] next_adr, output bit got);
    exp_t e;
    got = 1'b0;
    e = sb.pop_front();
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      trace[k] = {sram_ce_no, sram_we_no, sram_oe_no, sram_dat_oe_o, sram_lb_no, sram_ub_no,
                  sram_addr_o, sram_dat_o};
      if (ack_o || err_o) begin
        got = 1'b1;
        check({e.tag, ":ack"}, 64'(ack_o), 64'(!e.is_err));
        check({e.tag, ":err"}, 64'(err_o), 64'(e.is_err));
        check({e.tag, ":latency"}, 64'(k), 64'(e.lat));
        if (e.chk_dat) check({e.tag, ":data"}, 64'(dat_o), 64'(e.dat));
        if (release_bus) begin
          cyc_i = 1'b0; stb_i = 1'b0;
        end else begin
          adr_i = next_adr;
        end
      end
    end
    check({e.tag, ":responded"}, 64'(got), 64'(1));
    if (release_bus && got) begin
      @(negedge clk);
      check({e.tag, ":pulse_one_cycle"}, 64'({ack_o, err_o}), 64'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          got;
    int          nacks;
    int          off;
    logic [39:0] ev;
    logic [16:0] a17;
    logic        hf;
    logic [31:0] v;

    reset_ni = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    adr_i = 30'h0; dat_i = 32'h0; sel_i = 4'h0;
    #12;
    check("reset:ctrl", 64'({ack_o, err_o, sram_dat_oe_o, sram_ce_no, sram_oe_no, sram_we_no,
                             sram_lb_no, sram_ub_no}), 64'(8'b0001_1111));
    check("reset:dat_o", 64'(dat_o), 64'(0));
    check("reset:sram_addr", 64'(sram_addr_o), 64'(0));
    check("reset:sram_dat", 64'(sram_dat_o), 64'(0));
    check("reset:state", 64'(dut.state_r), 64'(ST_IDLE));
    @(negedge clk); reset_ni = 1'b1;
    @(negedge clk);

    // Full-word write: two phases, BEEF at 0x20 then DEAD at 0x21
    expect_resp("wr_full", 1'b0, 32'h0, 1'b0, 2 * P);
    issue(30'h10, 32'hDEAD_BEEF, 1'b1, 4'hF);
    ref_write(32'h10, 32'hDEAD_BEEF, 4'hF);
    collect(1'b1, 30'h0, got);
    a17 = 17'h10;
    for (int k = 0; k < 2 * P; k++) begin
      hf = (k >= P);
      ev = {1'b0, (k % P == 0), 1'b1, 1'b1, 1'b0, 1'b0, a17, hf, hf ? 16'hDEAD : 16'hBEEF};
      check($sformatf("wr_full:trace%0d", k), 64'(trace[k]), 64'(ev));
    end
    check("wr_full:released", 64'(trace[2 * P][39:36]), 64'(4'b1110));

    // Full-word read back
    expect_resp("rd_full", 1'b0, ref_read(32'h10), 1'b1, 2 * P);
    issue(30'h10, 32'h0, 1'b0, 4'hF);
    collect(1'b1, 30'h0, got);
    for (int k = 0; k < 2 * P; k++) begin
      hf = (k >= P);
      check($sformatf("rd_full:trace%0d", k), 64'(trace[k][39:16]),
            64'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a17, hf}));
    end
    check("rd_full:released", 64'(trace[2 * P][39:36]), 64'(4'b1110));

    // Upper-half-only write: single phase at 0x21
    expect_resp("wr_hi", 1'b0, 32'h0, 1'b0, P);
    issue(30'h10, 32'h1234_5678, 1'b1, 4'hC);
    ref_write(32'h10, 32'h1234_5678, 4'hC);
    collect(1'b1, 30'h0, got);
    for (int k = 0; k < P; k++) begin
      ev = {1'b0, (k == 0), 1'b1, 1'b1, 1'b0, 1'b0, a17, 1'b1, 16'h1234};
      check($sformatf("wr_hi:trace%0d", k), 64'(trace[k]), 64'(ev));
    end
    expect_resp("rd_merge", 1'b0, ref_read(32'h10), 1'b1, 2 * P);
    issue(30'h10, 32'h0, 1'b0, 4'hF);
    collect(1'b1, 30'h0, got);

    // First out-of-range word
    expect_resp("err_range", 1'b1, 32'h0, 1'b0, 0);
    issue(30'h0002_0000, 32'h0, 1'b0, 4'hF);
    collect(1'b1, 30'h0, got);
    check("err_range:ce_idle", 64'(trace[0][39]), 64'(1));

    // Preload a cache line through the bus
    for (int i = 0; i < 16; i++) begin
      v = 32'h1000_0000 + 32'(i) * 32'h0011_0101;
      expect_resp($sformatf("preload%0d", i), 1'b0, 32'h0, 1'b0, 2 * P);
      issue(30'h40 + 30'(i), v, 1'b1, 4'hF);
      ref_write(32'h40 + i, v, 4'hF);
      collect(1'b1, 30'h0, got);
    end

    // Line fill: stb held, address advanced on each ack
    nacks = 0;
    expect_resp("burst0", 1'b0, ref_read(32'h40), 1'b1, 2 * P);
    issue(30'h40, 32'h0, 1'b0, 4'hF);
    for (int i = 0; i < 16; i++) begin
      if (i < 15) expect_resp($sformatf("burst%0d", i + 1), 1'b0, ref_read(32'h41 + i), 1'b1, 2 * P + 1);
      collect(i == 15, 30'h41 + 30'(i), got);
      if (got) nacks++;
      off = (i == 0) ? 0 : 1;
      a17 = 17'h40 + 17'(i);
      check($sformatf("burst%0d:addr_lo", i), 64'(trace[off][33:16]), 64'({a17, 1'b0}));
      check($sformatf("burst%0d:addr_hi", i), 64'(trace[off + 2 * P - 1][33:16]), 64'({a17, 1'b1}));
    end
    check("burst:acks", 64'(nacks), 64'(16));

    // Abort: cyc dropped during the LO phase
    issue(30'h10, 32'h0, 1'b0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    cyc_i = 1'b0; stb_i = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ack_o || err_o) got = 1'b1;
    end
    check("abort:no_response", 64'(got), 64'(0));
    check("abort:state", 64'(dut.state_r), 64'(ST_IDLE));

    // Reset asserted mid-phase releases strobes at once
    issue(30'h12, 32'h55AA_55AA, 1'b1, 4'hF);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid:we_active", 64'(sram_we_no), 64'(0));
    #2 reset_ni = 1'b0;
    #1;
    check("rst_mid:ctrl", 64'({ack_o, err_o, sram_dat_oe_o, sram_ce_no, sram_oe_no, sram_we_no,
                               sram_lb_no, sram_ub_no}), 64'(8'b0001_1111));
    check("rst_mid:state", 64'(dut.state_r), 64'(ST_IDLE));
    cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge clk); reset_ni = 1'b1;
    @(negedge clk);

    expect_resp("rd_after_rst", 1'b0, ref_read(32'h10), 1'b1, 2 * P);
    issue(30'h10, 32'h0, 1'b0, 4'hF);
    collect(1'b1, 30'h0, got);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_wb_sram_slave.md
Name: rv32i_wb_sram_slave

Overview:
Wishbone classic responder that serves 32-bit word accesses from the shared bus, including instruction-cache line fills and vtable reads, out of an external asynchronous 16-bit SRAM. Each word access becomes up to two timed halfword SRAM cycles, with programmable wait states. Out-of-range addresses terminate with err_o. The block sits on the slave side of the bus arbiter, opposite the rv32i masters.

Parameters:
ADDR_W, 30, Wishbone word-address width (XLEN-2).
SRAM_ADDR_W, 18, SRAM halfword-address width; 2**(SRAM_ADDR_W-1) words are mapped.
WAIT_STATES, 1, extra strobe cycles per halfword phase (0..15).

Ports:
clk_i  in  1  single clock
reset_ni  in  1  asynchronous reset, active-low
adr_i  in  ADDR_W  word address
dat_i  in  32  write data
dat_o  out  32  read data, valid while ack_o is high
we_i  in  1  write enable
sel_i  in  4  byte lane selects
cyc_i  in  1  bus cycle
stb_i  in  1  strobe
ack_o  out  1  normal termination
err_o  out  1  error termination
sram_addr_o  out  SRAM_ADDR_W  halfword address
sram_dat_i  in  16  SRAM read data
sram_dat_o  out  16  SRAM write data
sram_dat_oe_o  out  1  pad output enable for sram_dat_o
sram_ce_no  out  1  chip enable, active-low
sram_oe_no  out  1  output enable, active-low
sram_we_no  out  1  write enable, active-low
sram_lb_no  out  1  low-byte enable, active-low
sram_ub_no  out  1  high-byte enable, active-low

Behaviour:
- Reset (reset_ni low, asynchronous): state IDLE; ack_o=0, err_o=0, dat_o=0, sram_addr_o=0, sram_dat_o=0, sram_dat_oe_o=0; sram_ce_no, sram_oe_no, sram_we_no, sram_lb_no, sram_ub_no all =1. A reset asserted mid-access releases the SRAM strobes immediately.
- States: IDLE, LO, HI, ACK, ERR.
- IDLE: on a clock edge with cyc_i & stb_i:
  - If adr_i[ADDR_W-1:SRAM_ADDR_W-1] != 0, go to ERR.
  - Otherwise latch adr, dat, we and sel. Go to LO if sel[1:0] != 0, else HI if sel[3:2] != 0, else ACK.
- Phase (LO or HI) length is WAIT_STATES+2 cycles.
  - Cycle 0 (setup): sram_addr_o = {adr[SRAM_ADDR_W-2:0], half} with half=0 for LO and 1 for HI; sram_ce_no=0; lb/ub = ~sel bits of that half.
  - Read: sram_oe_no=0 for the whole phase; sram_dat_oe_o=0; sram_dat_i is registered into the matching dat_o half at the end of the last cycle.
  - Write: sram_dat_oe_o=1 and sram_dat_o = the matching data half for the whole phase; sram_we_no=0 in cycles 1..WAIT_STATES+1 only.
- At phase end: LO goes to HI if sel[3:2] != 0, else ACK; HI goes to ACK. If cyc_i is low at phase end, go to IDLE with no ack (abort). Read-data halves not fetched hold their previous value.
- ACK: ack_o=1 for exactly one cycle, then IDLE. ERR: err_o=1 for exactly one cycle, then IDLE. All SRAM strobes are released in both states.
- Latency: ack_o rises N*(WAIT_STATES+2) edges after the IDLE sampling edge, where N = number of halves selected (0..2). With N=0, ack follows one edge later.
- Back-to-back: an initiator holding stb_i and changing adr_i on ack is served again. IDLE samples the next request on the edge after ACK.
- ack_o and err_o are never both high. stb_i is ignored outside IDLE.

Decomposition:
- Shared package rv32i_wb_pkg holds:
  - state encodings;
  - Wishbone data and select widths (32, 4);
  - SRAM_HALF_LO/HI constants.
- One natural sub-module, rv32i_sram_phase_timer: a down-counter loaded with WAIT_STATES+1 on setup, producing strobe_window and phase_last.

Test Plan:
- WAIT_STATES=1; write adr=0x10, dat=0xDEADBEEF, sel=1111 → two 3-cycle phases at sram_addr 0x20 (BEEF) then 0x21 (DEAD); we_no low 2 cycles each; ack_o one cycle at edge 6.
- Read adr=0x10 after that write → dat_o=0xDEADBEEF while ack_o=1; oe_no low, dat_oe_o=0 throughout.
- Write sel=1100, dat=0x12345678 → LO phase skipped; one phase at 0x21 with ub_no=0, lb_no=0, data 0x1234; ack at edge 3.
- adr=2**(SRAM_ADDR_W-1) → err_o=1 for one cycle, ack_o=0, sram_ce_no stays 1.
- 16-word burst with stb_i held and adr_i advanced on each ack (line-fill pattern) → 16 acks, addresses sequential, data matching preloaded model.
- Drop cyc_i during the LO phase, then assert reset_ni low mid-phase → no ack; strobes release immediately on reset; state IDLE.
